// File: rtl/heat_color_writer.sv
// Heat-map colour writer: scans one row of signed node amplitudes, bins each one
// against a programmable descending threshold table and streams RGB332 pixels out.
module heat_color_writer #(
    parameter int NODES   = 64,
    parameter int ROWS    = 64,
    parameter int DATA_W  = 32,
    parameter int NUM_THR = 7,
    localparam int COL_W  = $clog2(NODES),
    localparam int ROW_W  = $clog2(ROWS),
    localparam int ADDR_W = COL_W + ROW_W
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_row,
    input  logic [ROW_W-1:0]  row_sel,
    output logic [COL_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_val,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [2:0]        cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [ROW_W-1:0]  cur_row
);
    localparam int K_W  = $clog2(NUM_THR + 1);
    localparam int FRAC = DATA_W - 5;

    typedef enum logic [2:0] {IDLE, FETCH, CLASS, WRITE, DONE} state_t;

    function automatic logic [DATA_W-1:0] thr_default(input int i);
        logic [DATA_W-1:0] whole;
        whole = DATA_W'(NUM_THR - 1 - 2 * i);
        return whole << FRAC;
    endfunction

    function automatic logic [7:0] lut_default(input int i);
        logic [7:0] c;
        case (i)
            0:       c = 8'hE0;
            1:       c = 8'hE8;
            2:       c = 8'hCD;
            3:       c = 8'h00;
            4:       c = 8'h77;
            5:       c = 8'hF8;
            6:       c = 8'hE3;
            7:       c = 8'hFF;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   rd_idx_reg, rd_idx_next;
    logic [DATA_W-1:0]  val_q_reg, val_q_next;
    logic               wr_valid_reg, wr_valid_next;
    logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
    logic [7:0]         wr_data_reg, wr_data_next;
    logic [ROW_W-1:0]   cur_row_reg, cur_row_next;
    // Set once a scan has auto-advanced the row, so the next auto start continues from it.
    logic               row_chain_reg, row_chain_next;

    logic [DATA_W-1:0]  thr_reg [NUM_THR];
    logic [7:0]         lut_reg [NUM_THR+1];
    logic               cfg_wr;
    logic [NUM_THR-1:0] ge;
    logic [K_W-1:0]     band;
    logic [7:0]         color;

    assign cfg_wr = cfg_we && (state_reg == IDLE);

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_THR; i++) thr_reg[i] <= thr_default(i);
            for (int i = 0; i <= NUM_THR; i++) lut_reg[i] <= lut_default(i);
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_THR; i++)
                if (!cfg_sel && int'(cfg_idx) == i) thr_reg[i] <= cfg_data;
            for (int i = 0; i <= NUM_THR; i++)
                if (cfg_sel && int'(cfg_idx) == i) lut_reg[i] <= cfg_data[7:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THR; gi++) begin : g_cmp
            assign ge[gi] = $signed(val_q_reg) >= $signed(thr_reg[gi]);
        end
    endgenerate

    // Lowest matching index wins, so equality lands in the higher band.
    always_comb begin
        band = K_W'(NUM_THR);
        for (int i = NUM_THR - 1; i >= 0; i--)
            if (ge[i]) band = K_W'(i);
    end

    assign color = lut_reg[band];

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rd_idx_reg    <= '0;
            val_q_reg     <= '0;
            wr_valid_reg  <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            cur_row_reg   <= '0;
            row_chain_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_idx_reg    <= rd_idx_next;
            val_q_reg     <= val_q_next;
            wr_valid_reg  <= wr_valid_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            cur_row_reg   <= cur_row_next;
            row_chain_reg <= row_chain_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rd_idx_next    = rd_idx_reg;
        val_q_next     = val_q_reg;
        wr_valid_next  = wr_valid_reg;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        cur_row_next   = cur_row_reg;
        row_chain_next = row_chain_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cur_row_next = (auto_row && row_chain_reg) ? cur_row_reg : row_sel;
                    rd_idx_next  = '0;
                    state_next   = FETCH;
                end
            end
            FETCH: begin
                val_q_next = rd_val;
                state_next = CLASS;
            end
            CLASS: begin
                wr_data_next  = color;
                wr_addr_next  = ADDR_W'(cur_row_reg) * ADDR_W'(NODES) + ADDR_W'(rd_idx_reg);
                wr_valid_next = 1'b1;
                state_next    = WRITE;
            end
            WRITE: begin
                if (wr_ready) begin
                    wr_valid_next = 1'b0;
                    if (rd_idx_reg == COL_W'(NODES - 1)) begin
                        state_next = DONE;
                    end else begin
                        rd_idx_next = rd_idx_reg + COL_W'(1);
                        state_next  = FETCH;
                    end
                end
            end
            DONE: begin
                state_next     = IDLE;
                row_chain_next = auto_row;
                if (auto_row)
                    cur_row_next = (cur_row_reg == ROW_W'(ROWS - 1)) ? '0
                                                                     : cur_row_reg + ROW_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_idx   = rd_idx_reg;
    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign cur_row  = cur_row_reg;
    assign busy     = (state_reg == FETCH) || (state_reg == CLASS) || (state_reg == WRITE);
    assign done     = (state_reg == DONE);

endmodule
